// File: rtl/exe_mem_vec_stage.sv
// EXE->MEM pipeline stage for the vector datapath: valid/ready handshake with a
// 2-entry skid buffer (main entry drives outputs, skid entry absorbs backpressure).
module exe_mem_vec_stage #(
    parameter int LANES  = 4,
    parameter int DATA_W = 32,
    parameter int RD_W   = 4,
    parameter int CTRL_W = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    stop,
    input  logic                    flush,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [CTRL_W-1:0]       ctrl_in,
    input  logic [RD_W-1:0]         rd_in,
    input  logic [LANES-1:0]        cmp_in,
    input  logic [LANES*DATA_W-1:0] data_in,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [CTRL_W-1:0]       ctrl_out,
    output logic [RD_W-1:0]         rd_out,
    output logic [LANES-1:0]        cmp_out,
    output logic [LANES*DATA_W-1:0] data_out,
    output logic [1:0]              occupancy
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t state_q, state_d;

    logic [CTRL_W-1:0]       main_ctrl_q, skid_ctrl_q;
    logic [RD_W-1:0]         main_rd_q,   skid_rd_q;
    logic [LANES-1:0]        main_cmp_q,  skid_cmp_q;
    logic [LANES*DATA_W-1:0] main_data_q, skid_data_q;

    logic acc, pop;
    logic ld_main_in, ld_skid_in, ld_main_skid;

    // stop is the only combinational path into in_ready; the rest comes from state
    assign in_ready  = (state_q != FULL) && !stop;
    assign out_valid = (state_q != EMPTY);
    assign acc       = in_valid && in_ready;
    assign pop       = out_valid && out_ready && !stop;

    always_comb begin
        state_d      = state_q;
        ld_main_in   = 1'b0;
        ld_skid_in   = 1'b0;
        ld_main_skid = 1'b0;
        case (state_q)
            EMPTY: begin
                if (acc) begin
                    ld_main_in = 1'b1;
                    state_d    = ONE;
                end
            end
            ONE: begin
                // simultaneous accept and pop keeps one entry in flight per cycle
                if (acc && pop) begin
                    ld_main_in = 1'b1;
                end else if (acc) begin
                    ld_skid_in = 1'b1;
                    state_d    = FULL;
                end else if (pop) begin
                    state_d = EMPTY;
                end
            end
            FULL: begin
                if (pop) begin
                    ld_main_skid = 1'b1;
                    state_d      = ONE;
                end
            end
            default: state_d = EMPTY;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            state_q     <= EMPTY;
            main_ctrl_q <= '0;
            main_rd_q   <= '0;
            main_cmp_q  <= '0;
            main_data_q <= '0;
            skid_ctrl_q <= '0;
            skid_rd_q   <= '0;
            skid_cmp_q  <= '0;
            skid_data_q <= '0;
        end else begin
            state_q <= state_d;
            if (ld_main_in) begin
                main_ctrl_q <= ctrl_in;
                main_rd_q   <= rd_in;
                main_cmp_q  <= cmp_in;
                main_data_q <= data_in;
            end else if (ld_main_skid) begin
                main_ctrl_q <= skid_ctrl_q;
                main_rd_q   <= skid_rd_q;
                main_cmp_q  <= skid_cmp_q;
                main_data_q <= skid_data_q;
            end
            if (ld_skid_in) begin
                skid_ctrl_q <= ctrl_in;
                skid_rd_q   <= rd_in;
                skid_cmp_q  <= cmp_in;
                skid_data_q <= data_in;
            end
        end
    end

    // control bits are masked so a bubble never asserts regWrite/memWrite
    assign ctrl_out  = main_ctrl_q & {CTRL_W{out_valid}};
    assign rd_out    = main_rd_q;
    assign cmp_out   = main_cmp_q;
    assign data_out  = main_data_q;
    assign occupancy = state_q;

endmodule

// File: tb/tb_exe_mem_vec_stage.sv
// Directed bench for exe_mem_vec_stage: reset, streaming, backpressure, stall,
// flush and bubble gating with hand-computed expectations.
module tb_exe_mem_vec_stage;

    localparam int LANES  = 4;
    localparam int DATA_W = 32;
    localparam int RD_W   = 4;
    localparam int CTRL_W = 4;

    logic                    clk = 1'b0;
    logic                    reset, stop, flush;
    logic                    in_valid, in_ready;
    logic [CTRL_W-1:0]       ctrl_in;
    logic [RD_W-1:0]         rd_in;
    logic [LANES-1:0]        cmp_in;
    logic [LANES*DATA_W-1:0] data_in;
    logic                    out_valid, out_ready;
    logic [CTRL_W-1:0]       ctrl_out;
    logic [RD_W-1:0]         rd_out;
    logic [LANES-1:0]        cmp_out;
    logic [LANES*DATA_W-1:0] data_out;
    logic [1:0]              occupancy;

    int n_checks = 0;
    int n_fail   = 0;

    exe_mem_vec_stage #(
        .LANES(LANES), .DATA_W(DATA_W), .RD_W(RD_W), .CTRL_W(CTRL_W)
    ) dut (
        .clk(clk), .reset(reset), .stop(stop), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .ctrl_in(ctrl_in), .rd_in(rd_in), .cmp_in(cmp_in), .data_in(data_in),
        .out_valid(out_valid), .out_ready(out_ready),
        .ctrl_out(ctrl_out), .rd_out(rd_out), .cmp_out(cmp_out), .data_out(data_out),
        .occupancy(occupancy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // advance one clock; inputs are changed and outputs sampled 1ns after the edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1; stop = 1'b0; flush = 1'b0;
        in_valid = 1'b0; out_ready = 1'b0;
        ctrl_in = '0; rd_in = '0; cmp_in = '0; data_in = '0;
        step(); step();
        reset = 1'b0;
        check("rst_valid", out_valid, 0);
        check("rst_occ", occupancy, 0);
        check("rst_ctrl", ctrl_out, 0);
        check("rst_rd", rd_out, 0);
        check("rst_cmp", cmp_out, 0);
        check("rst_data", data_out, 0);
        check("rst_ready", in_ready, 1);

        // streaming: one entry per cycle, each visible one cycle after acceptance
        out_ready = 1'b1;
        in_valid  = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            rd_in = RD_W'(k);
            step();
            check("strm_valid", out_valid, 1);
            check("strm_rd", rd_out, k);
            check("strm_occ", occupancy, 1);
        end
        in_valid = 1'b0;
        step();
        check("strm_drain_valid", out_valid, 0);
        check("strm_drain_occ", occupancy, 0);
        check("strm_keep_rd", rd_out, 8);

        // backpressure: A in main, B in skid, C held upstream
        out_ready = 1'b0;
        in_valid  = 1'b1;
        rd_in = 4'd10; step();
        rd_in = 4'd11; step();
        rd_in = 4'd12;
        check("bp_occ_full", occupancy, 2);
        check("bp_ready", in_ready, 0);
        check("bp_main_a", rd_out, 10);
        step();
        check("bp_hold_occ", occupancy, 2);
        check("bp_hold_rd", rd_out, 10);
        out_ready = 1'b1;
        step();
        check("bp_b_rd", rd_out, 11);
        check("bp_b_occ", occupancy, 1);
        step();
        check("bp_c_rd", rd_out, 12);
        check("bp_c_valid", out_valid, 1);
        in_valid = 1'b0;
        step();
        check("bp_empty", occupancy, 0);

        // stall while FULL
        out_ready = 1'b0;
        in_valid  = 1'b1;
        rd_in = 4'd5; step();
        rd_in = 4'd6; step();
        in_valid  = 1'b0;
        stop      = 1'b1;
        out_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            check("stall_ready", in_ready, 0);
            step();
            check("stall_occ", occupancy, 2);
            check("stall_rd", rd_out, 5);
            check("stall_valid", out_valid, 1);
        end
        stop = 1'b0;
        step();
        check("stall_rel_rd", rd_out, 6);
        check("stall_rel_occ", occupancy, 1);
        step();
        check("stall_rel_empty", occupancy, 0);

        // stop also blocks acceptance when empty
        stop = 1'b1;
        #1;
        check("stop_ready", in_ready, 0);
        stop = 1'b0;

        // flush while FULL with an entry on offer
        out_ready = 1'b0;
        in_valid  = 1'b1;
        data_in   = 128'h1234;
        rd_in = 4'd7; step();
        rd_in = 4'd8; step();
        check("fl_pre_occ", occupancy, 2);
        flush = 1'b1;
        rd_in = 4'd9;
        step();
        flush    = 1'b0;
        in_valid = 1'b0;
        check("fl_valid", out_valid, 0);
        check("fl_occ", occupancy, 0);
        check("fl_data", data_out, 0);
        check("fl_rd", rd_out, 0);
        out_ready = 1'b1;
        step();
        check("fl_absent", occupancy, 0);

        // bubble gating of control bits
        out_ready = 1'b0;
        in_valid  = 1'b1;
        ctrl_in   = 4'hF;
        rd_in     = 4'd3;
        cmp_in    = 4'b1010;
        data_in   = {32'h1111_2222, 32'hEEEE_FFFF, 32'hCCCC_DDDD, 32'hAAAA_BBBB};
        step();
        in_valid = 1'b0;
        check("bub_ctrl_valid", ctrl_out, 4'hF);
        check("bub_lane0", data_out[31:0], 32'hAAAA_BBBB);
        check("bub_lane1", data_out[63:32], 32'hCCCC_DDDD);
        check("bub_lane2", data_out[95:64], 32'hEEEE_FFFF);
        check("bub_lane3", data_out[127:96], 32'h1111_2222);
        check("bub_cmp", cmp_out, 4'b1010);
        out_ready = 1'b1;
        step();
        check("bub_valid", out_valid, 0);
        check("bub_ctrl_gated", ctrl_out, 0);
        check("bub_keep_lane0", data_out[31:0], 32'hAAAA_BBBB);

        // reset mid-transfer discards held entries
        out_ready = 1'b0;
        in_valid  = 1'b1;
        step(); step();
        reset    = 1'b1;
        in_valid = 1'b0;
        step();
        reset = 1'b0;
        check("rst2_occ", occupancy, 0);
        check("rst2_ctrl", ctrl_out, 0);
        check("rst2_data", data_out, 0);
        check("rst2_ready", in_ready, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
